// File: rtl/validador_senha_pkg.sv
// Shared types for the password validator: packed entry/configuration formats,
// the empty-entry marker and the sequencer state encoding.
package validador_senha_pkg;

    typedef logic [19:0][3:0] senhaPac_t;

    typedef struct packed {
        senhaPac_t senha_master;
        senhaPac_t senha_1;
        senhaPac_t senha_2;
        senhaPac_t senha_3;
        senhaPac_t senha_4;
    } setupPac_t;

    localparam senhaPac_t SENHA_VAZIA = {20{4'hF}};
    localparam int        N_SLOTS     = 5;

    typedef enum logic [1:0] {
        IDLE,
        COMPARA,
        RESULTADO,
        BLOQUEIO
    } estado_validador_t;

endpackage

// File: rtl/temporizador_bloqueio.sv
// Lockout timer: a CLK_HZ prescaler feeding a 16-bit seconds down-counter.
// fim is high during the cycle whose edge takes tempo from 1 to 0.
module temporizador_bloqueio #(
    parameter int CLK_HZ = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        carrega,
    input  logic [15:0] valor,
    output logic [15:0] tempo,
    output logic        fim
);

    localparam int            PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] TERM = PW'(CLK_HZ - 1);

    logic [PW-1:0] prescaler;
    logic          tick;

    assign tick = (tempo != 16'd0) && (prescaler == TERM);
    assign fim  = tick && (tempo == 16'd1);

    // The prescaler only runs while seconds remain, so the counter parks at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            tempo     <= 16'd0;
        end else if (carrega) begin
            prescaler <= '0;
            tempo     <= valor;
        end else if (tempo != 16'd0) begin
            if (tick) begin
                prescaler <= '0;
                tempo     <= tempo - 16'd1;
            end else begin
                prescaler <= prescaler + PW'(1);
            end
        end
    end

endmodule

// File: rtl/validador_senha.sv
// Password validator: checks an entry against five snapshotted slots with one
// shared comparator, counts consecutive failures and enforces a timed lockout.
module validador_senha
    import validador_senha_pkg::*;
#(
    parameter int MAX_TENTATIVAS = 5,
    parameter int CLK_HZ         = 1000,
    parameter int BLOQUEIO_S     = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  senhaPac_t   senha_in,
    input  logic        senha_valid,
    input  setupPac_t   setup_in,
    output logic        busy,
    output logic        resultado_valid,
    output logic        senha_ok,
    output logic        master_ok,
    output logic [2:0]  slot_idx,
    output logic [2:0]  tentativas,
    output logic        bloqueado,
    output logic [15:0] tempo_restante
);

    localparam logic [2:0] MAX_T  = 3'(MAX_TENTATIVAS);
    localparam logic [2:0] ULTIMO = 3'(N_SLOTS - 1);

    estado_validador_t estado;
    senhaPac_t         senha_lat;
    senhaPac_t         slots [N_SLOTS];
    logic [2:0]        indice;
    logic              vazia;
    logic              achou;
    logic [2:0]        idx_achado;

    senhaPac_t         slot_atual;
    logic              casou;
    logic [2:0]        prox_tent;
    logic              carrega;
    logic              fim;

    // Single comparator walks the snapshot; an empty slot can never match.
    assign slot_atual = slots[indice];
    assign casou      = (slot_atual == senha_lat) && (slot_atual != SENHA_VAZIA);
    assign prox_tent  = (tentativas < MAX_T) ? tentativas + 3'd1 : tentativas;
    assign carrega    = (estado == RESULTADO) && !achou && !vazia && (prox_tent == MAX_T);

    temporizador_bloqueio #(
        .CLK_HZ (CLK_HZ)
    ) u_temporizador (
        .clk     (clk),
        .rst     (rst),
        .carrega (carrega),
        .valor   (16'(BLOQUEIO_S)),
        .tempo   (tempo_restante),
        .fim     (fim)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado          <= IDLE;
            senha_lat       <= SENHA_VAZIA;
            for (int i = 0; i < N_SLOTS; i++) slots[i] <= SENHA_VAZIA;
            indice          <= 3'd0;
            vazia           <= 1'b0;
            achou           <= 1'b0;
            idx_achado      <= 3'd0;
            busy            <= 1'b0;
            resultado_valid <= 1'b0;
            senha_ok        <= 1'b0;
            master_ok       <= 1'b0;
            slot_idx        <= 3'd0;
            tentativas      <= 3'd0;
            bloqueado       <= 1'b0;
        end else begin
            resultado_valid <= 1'b0;
            unique case (estado)
                IDLE: begin
                    if (senha_valid) begin
                        senha_lat  <= senha_in;
                        slots[0]   <= setup_in.senha_master;
                        slots[1]   <= setup_in.senha_1;
                        slots[2]   <= setup_in.senha_2;
                        slots[3]   <= setup_in.senha_3;
                        slots[4]   <= setup_in.senha_4;
                        indice     <= 3'd0;
                        vazia      <= (senha_in == SENHA_VAZIA);
                        achou      <= 1'b0;
                        idx_achado <= 3'd0;
                        busy       <= 1'b1;
                        estado     <= COMPARA;
                    end
                end
                COMPARA: begin
                    if (vazia) begin
                        estado <= RESULTADO;
                    end else if (casou) begin
                        achou      <= 1'b1;
                        idx_achado <= indice;
                        estado     <= RESULTADO;
                    end else if (indice == ULTIMO) begin
                        estado <= RESULTADO;
                    end else begin
                        indice <= indice + 3'd1;
                    end
                end
                // Empty entries report failure without counting as an attempt.
                RESULTADO: begin
                    resultado_valid <= 1'b1;
                    senha_ok        <= achou;
                    master_ok       <= achou && (idx_achado == 3'd0);
                    slot_idx        <= achou ? idx_achado : 3'd0;
                    if (achou) begin
                        tentativas <= 3'd0;
                        busy       <= 1'b0;
                        estado     <= IDLE;
                    end else if (vazia) begin
                        busy   <= 1'b0;
                        estado <= IDLE;
                    end else begin
                        tentativas <= prox_tent;
                        if (prox_tent == MAX_T) begin
                            bloqueado <= 1'b1;
                            estado    <= BLOQUEIO;
                        end else begin
                            busy   <= 1'b0;
                            estado <= IDLE;
                        end
                    end
                end
                BLOQUEIO: begin
                    if (fim) begin
                        bloqueado  <= 1'b0;
                        tentativas <= 3'd0;
                        busy       <= 1'b0;
                        estado     <= IDLE;
                    end
                end
                default: estado <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_validador_senha.sv
// Self-checking bench for validador_senha: expected result pulses are queued at
// strobe time and matched (cycle and fields) when resultado_valid appears.
module tb_validador_senha;
    import validador_senha_pkg::*;

    localparam int CLK_HZ     = 4;
    localparam int BLOQUEIO_S = 3;
    localparam int MAX_T      = 3;

    typedef struct {
        int         ciclo;
        logic       ok;
        logic       master;
        logic [2:0] idx;
        logic [2:0] tent;
    } esperado_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    senhaPac_t   senha_in;
    logic        senha_valid = 1'b0;
    setupPac_t   setup_in;
    logic        busy;
    logic        resultado_valid;
    logic        senha_ok;
    logic        master_ok;
    logic [2:0]  slot_idx;
    logic [2:0]  tentativas;
    logic        bloqueado;
    logic [15:0] tempo_restante;

    int          ciclo    = 0;
    int          n_checks = 0;
    int          n_pass   = 0;
    esperado_t   fila[$];
    esperado_t   e_mon;

    senhaPac_t   s1234;
    senhaPac_t   s9876;
    senhaPac_t   s5555;
    senhaPac_t   s0000;

    validador_senha #(
        .MAX_TENTATIVAS (MAX_T),
        .CLK_HZ         (CLK_HZ),
        .BLOQUEIO_S     (BLOQUEIO_S)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .senha_in        (senha_in),
        .senha_valid     (senha_valid),
        .setup_in        (setup_in),
        .busy            (busy),
        .resultado_valid (resultado_valid),
        .senha_ok        (senha_ok),
        .master_ok       (master_ok),
        .slot_idx        (slot_idx),
        .tentativas      (tentativas),
        .bloqueado       (bloqueado),
        .tempo_restante  (tempo_restante)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ciclo <= ciclo + 1;

    // Scoreboard side: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && resultado_valid) begin
            if (fila.size() == 0) begin
                n_checks++;
                $display("[TB] FAIL pulso_inesperado: resultado_valid=1 at cycle %0d, required no pulse", ciclo);
            end else begin
                e_mon = fila.pop_front();
                n_checks++;
                if (ciclo !== e_mon.ciclo)
                    $display("[TB] FAIL latencia: pulse at cycle %0d, required %0d", ciclo, e_mon.ciclo);
                else
                    n_pass++;
                n_checks++;
                if ({senha_ok, master_ok, slot_idx, tentativas} !== {e_mon.ok, e_mon.master, e_mon.idx, e_mon.tent})
                    $display("[TB] FAIL campos: ok=%0b master=%0b idx=%0d tent=%0d, required ok=%0b master=%0b idx=%0d tent=%0d",
                             senha_ok, master_ok, slot_idx, tentativas, e_mon.ok, e_mon.master, e_mon.idx, e_mon.tent);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic envia(input senhaPac_t s, input int lat, input bit espera,
                         input logic ok, input logic mst, input logic [2:0] idx, input logic [2:0] tent);
        esperado_t e;
        @(negedge clk);
        senha_in    = s;
        senha_valid = 1'b1;
        if (espera) begin
            e.ciclo  = ciclo + 1 + lat;
            e.ok     = ok;
            e.master = mst;
            e.idx    = idx;
            e.tent   = tent;
            fila.push_back(e);
        end
        @(negedge clk);
        senha_valid = 1'b0;
    endtask

    task automatic aguarda();
        for (int i = 0; i < 40 && fila.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, resultado_valid, senha_ok, master_ok, slot_idx, tentativas, bloqueado, tempo_restante} !== '0)
            $display("[TB] FAIL reset_saidas: busy=%0b rv=%0b ok=%0b tent=%0d bloq=%0b tempo=%0d, required all 0",
                     busy, resultado_valid, senha_ok, tentativas, bloqueado, tempo_restante);
        else
            n_pass++;
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0)
            $display("[TB] FAIL reset_idle_busy: busy=%0b, required 0", busy);
        else
            n_pass++;
    endtask

    task automatic test_master();
        envia(s1234, 2, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0);
        #1;
        n_checks++;
        if (busy !== 1'b1)
            $display("[TB] FAIL master_busy: busy=%0b, required 1", busy);
        else
            n_pass++;
        aguarda();
        n_checks++;
        if (fila.size() != 0)
            $display("[TB] FAIL master_timeout: %0d pulses outstanding, required 0", fila.size());
        else
            n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if ({resultado_valid, senha_ok, master_ok, busy} !== 4'b0110)
            $display("[TB] FAIL master_hold: rv=%0b ok=%0b master=%0b busy=%0b, required rv=0 ok=1 master=1 busy=0",
                     resultado_valid, senha_ok, master_ok, busy);
        else
            n_pass++;
    endtask

    task automatic test_user_slot();
        setup_in.senha_3 = s9876;
        envia(s9876, 5, 1'b1, 1'b1, 1'b0, 3'd3, 3'd0);
        // Live setup changes after the strobe must not affect the result.
        setup_in.senha_master = s9876;
        setup_in.senha_3      = s0000;
        aguarda();
        n_checks++;
        if (fila.size() != 0)
            $display("[TB] FAIL slot3_timeout: %0d pulses outstanding, required 0", fila.size());
        else
            n_pass++;
        setup_in.senha_master = s1234;
        setup_in.senha_3      = SENHA_VAZIA;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        envia(s5555, 6, 1'b1, 1'b0, 1'b0, 3'd0, 3'd1);
        repeat (2) @(negedge clk);
        senha_in    = s1234;
        senha_valid = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b1)
            $display("[TB] FAIL b2b_busy: busy=%0b, required 1", busy);
        else
            n_pass++;
        @(negedge clk);
        senha_valid = 1'b0;
        aguarda();
        repeat (6) @(negedge clk);
        #1;
        n_checks++;
        if (fila.size() != 0 || tentativas !== 3'd1)
            $display("[TB] FAIL b2b_final: pending=%0d tent=%0d, required pending=0 tent=1", fila.size(), tentativas);
        else
            n_pass++;
    endtask

    task automatic test_empty();
        envia(SENHA_VAZIA, 2, 1'b1, 1'b0, 1'b0, 3'd0, 3'd1);
        senha_in    = SENHA_VAZIA;
        senha_valid = 1'b1;
        @(negedge clk);
        senha_valid = 1'b0;
        aguarda();
        repeat (4) @(negedge clk);
        #1;
        n_checks++;
        if (fila.size() != 0 || tentativas !== 3'd1)
            $display("[TB] FAIL vazia_final: pending=%0d tent=%0d, required pending=0 tent=1", fila.size(), tentativas);
        else
            n_pass++;
    endtask

    task automatic test_lockout();
        int l0;
        int k;
        envia(s1234, 2, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0);
        aguarda();
        for (int n = 1; n <= MAX_T; n++) begin
            envia(s5555, 6, 1'b1, 1'b0, 1'b0, 3'd0, 3'(n));
            aguarda();
            n_checks++;
            if (fila.size() != 0)
                $display("[TB] FAIL falha%0d_timeout: %0d pulses outstanding, required 0", n, fila.size());
            else
                n_pass++;
        end
        l0 = ciclo;
        for (int step = 0; step <= 12; step++) begin
            if (step > 0) begin
                @(negedge clk);
                #1;
            end
            k = ciclo - l0;
            if (k == 5) begin
                senha_in    = s1234;
                senha_valid = 1'b1;
            end
            if (k == 6) senha_valid = 1'b0;
            n_checks++;
            if (tempo_restante !== 16'(BLOQUEIO_S - k / CLK_HZ) || bloqueado !== (k < 12))
                $display("[TB] FAIL bloqueio_k%0d: tempo=%0d bloq=%0b, required tempo=%0d bloq=%0b",
                         k, tempo_restante, bloqueado, BLOQUEIO_S - k / CLK_HZ, (k < 12));
            else
                n_pass++;
            if (k == 8) begin
                n_checks++;
                if (tentativas !== 3'(MAX_T) || busy !== 1'b1)
                    $display("[TB] FAIL bloqueio_tent: tent=%0d busy=%0b, required tent=%0d busy=1", tentativas, busy, MAX_T);
                else
                    n_pass++;
            end
        end
        n_checks++;
        if (tentativas !== 3'd0 || busy !== 1'b0)
            $display("[TB] FAIL desbloqueio: tent=%0d busy=%0b, required tent=0 busy=0", tentativas, busy);
        else
            n_pass++;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_compare();
        envia(s5555, 0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, resultado_valid, senha_ok, master_ok, slot_idx, tentativas, bloqueado, tempo_restante} !== '0)
            $display("[TB] FAIL reset_meio: busy=%0b rv=%0b tent=%0d bloq=%0b, required all 0",
                     busy, resultado_valid, tentativas, bloqueado);
        else
            n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        envia(s1234, 2, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0);
        aguarda();
        n_checks++;
        if (fila.size() != 0)
            $display("[TB] FAIL pos_reset_timeout: %0d pulses outstanding, required 0", fila.size());
        else
            n_pass++;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        s1234 = {{16{4'hF}}, 16'h1234};
        s9876 = {{16{4'hF}}, 16'h9876};
        s5555 = {{16{4'hF}}, 16'h5555};
        s0000 = {{16{4'hF}}, 16'h0000};
        senha_in              = SENHA_VAZIA;
        setup_in.senha_master = s1234;
        setup_in.senha_1      = SENHA_VAZIA;
        setup_in.senha_2      = SENHA_VAZIA;
        setup_in.senha_3      = SENHA_VAZIA;
        setup_in.senha_4      = SENHA_VAZIA;

        test_reset();
        test_master();
        test_user_slot();
        test_back_to_back();
        test_empty();
        test_lockout();
        test_reset_mid_compare();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/validador_senha.md
Name: validador_senha

Overview:
Sequencer that checks a completed keypad entry against the five stored passwords (master, user 1-4) using one shared 80-bit comparator, one slot per cycle. It owns the failed-attempt counter and the lockout timer. It sits between the keypad digit collector and the operational lock FSM; the FSM consumes its one-cycle result pulse and its bloqueado flag.

Parameters:
MAX_TENTATIVAS, 5, consecutive failed entries that trigger lockout (1..7).
CLK_HZ, 1000, clk cycles per second; prescaler terminal count.
BLOQUEIO_S, 30, lockout duration in seconds (1..65535).

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
senha_in  input  senhaPac_t (80)  entered password: 20 BCD digits, unused digits 4'hF
senha_valid  input  1  one-cycle strobe; senha_in valid this cycle
setup_in  input  setupPac_t  live configuration; only senha_master and senha_1..4 are used
busy  output  1  comparison or lockout in progress; new strobes ignored
resultado_valid  output  1  one-cycle pulse; result fields valid this cycle
senha_ok  output  1  entry matched a slot (qualified by resultado_valid)
master_ok  output  1  match was slot 0 (master)
slot_idx  output  3  matching slot 0..4; 0 on failure
tentativas  output  3  current consecutive failure count
bloqueado  output  1  lockout active
tempo_restante  output  16  lockout seconds remaining; 0 when not locked

Behaviour:
- Reset: state IDLE; busy=0, resultado_valid=0, senha_ok=0, master_ok=0, slot_idx=0, tentativas=0, bloqueado=0, tempo_restante=0, prescaler=0. Reset mid-compare or mid-lockout aborts with no result pulse.
- States: IDLE, COMPARA, RESULTADO, BLOQUEIO.
- IDLE: on senha_valid, latch senha_in and snapshot all five slots from setup_in; index=0; go COMPARA. busy=1 from the next cycle.
- Empty entry: if senha_in == SENHA_VAZIA (all 4'hF), go directly to RESULTADO as failure. tentativas is not incremented.
- COMPARA: one slot per cycle, order master,1,2,3,4. A slot equal to SENHA_VAZIA never matches. On the first match, go RESULTADO with ok and slot_idx=index. If index 4 does not match, go RESULTADO as failure.
- Latency: strobe at cycle t; slot i is compared at t+1+i; resultado_valid at t+2+i on a match, t+6 on no match, t+2 for an empty entry.
- RESULTADO: resultado_valid=1 for exactly one cycle. senha_ok, master_ok and slot_idx hold their values until the next pulse.
  - Success: tentativas <= 0, then IDLE.
  - Failure on a non-empty entry: tentativas <= tentativas+1.
    - If the new value equals MAX_TENTATIVAS, go BLOQUEIO: bloqueado=1, tempo_restante=BLOQUEIO_S, prescaler=0.
    - Otherwise go IDLE.
- BLOQUEIO: prescaler counts 0..CLK_HZ-1. At terminal count, tempo_restante decrements.
  - When tempo_restante goes 1->0: bloqueado=0, tentativas=0, then IDLE.
  - senha_valid is ignored throughout; master does not override.
- senha_valid while busy (COMPARA, RESULTADO, BLOQUEIO) is dropped; nothing is queued.
- busy=0 only in IDLE.
- Changes to setup_in during COMPARA do not affect the comparison in flight (snapshot rule).
- tentativas saturates at MAX_TENTATIVAS and never wraps.

Decomposition:
- Shared package Tipos: existing senhaPac_t and setupPac_t; add constant SENHA_VAZIA = {20{4'hF}}, constant N_SLOTS = 5, and enum estado_validador_t {IDLE, COMPARA, RESULTADO, BLOQUEIO}.
- One sub-module: temporizador_bloqueio.
  - Behaviour: prescaler plus 16-bit seconds down-counter.
  - Ports: clk, rst, carrega, valor, tempo, fim.
  - Parameter: CLK_HZ.

Test Plan (CLK_HZ=4, BLOQUEIO_S=3, MAX_TENTATIVAS=3):
- Default setup (master ...F1234, users all F); strobe ...F1234 at t -> resultado_valid at t+2, senha_ok=1, master_ok=1, slot_idx=0, tentativas=0.
- senha_3 = ...F9876; strobe ...F9876 -> pulse at t+5, senha_ok=1, master_ok=0, slot_idx=3.
- Strobe ...F5555 three times -> pulses at t+6 with senha_ok=0; tentativas 1, 2, 3.
  - After the third: bloqueado=1, tempo_restante=3.
  - It decrements every 4 cycles.
  - 12 cycles after entry: bloqueado=0, tentativas=0.
- During that lockout, strobe ...F1234 -> no resultado_valid; tentativas stays 3.
- Strobe all-F -> pulse at t+2, senha_ok=0, tentativas unchanged. Strobe again at t+3 (while busy) -> dropped, no second pulse.
- Assert rst at t+3 of a compare -> all outputs at reset values immediately; no pulse; next strobe is processed normally.
